dmem_lsu_ctrl: RTL and testbench

// - CPU-side initiator for the 32b word-wide, byte-addressed data SRAM (async read, sync write, no byte enables).
// - Converts RV32 LB/LH/LW/LBU/LHU/SB/SH/SW requests into SRAM accesses.
// - Implements sub-word stores as read-modify-write.
// - Performs load lane extraction and sign/zero extension.
// - Flags misaligned accesses.

---
 rtl/dmem_lsu_ctrl.sv | 149 ++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_ctrl.sv
// Load/store controller for a word-wide, byte-addressed data SRAM without byte enables.
// Sub-word stores are done as read-modify-write; loads get lane extraction and sign/zero extension.
module dmem_lsu_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  input  logic              we_in,
  input  logic [1:0]        size_in,
  input  logic              unsigned_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              ready_out,
  output logic              done_out,
  output logic              err_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic [ADDR_W-1:0] mem_raddr_out,
  input  logic [DATA_W-1:0] mem_dout_in,
  output logic [ADDR_W-1:0] mem_waddr_out,
  output logic [DATA_W-1:0] mem_din_out,
  output logic              mem_we_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdataLo_q, wdataLo_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] din_q, din_d;

  logic              misaligned;
  logic [7:0]        byteLane;
  logic [15:0]       halfLane;
  logic [DATA_W-1:0] loadResult;
  logic [DATA_W-1:0] mergedWord;

  assign misaligned = (size_in == 2'b11)
                    | ((size_in == 2'b01) & addr_in[0])
                    | ((size_in == 2'b10) & (addr_in[1:0] != 2'b00));

  always_comb begin
    byteLane   = mem_dout_in[{addr_q[1:0], 3'b000} +: 8];
    halfLane   = mem_dout_in[{addr_q[1], 4'b0000} +: 16];
    loadResult = mem_dout_in;
    if (size_q == 2'b00) begin
      loadResult = {{24{~uns_q & byteLane[7]}}, byteLane};
    end else if (size_q == 2'b01) begin
      loadResult = {{16{~uns_q & halfLane[15]}}, halfLane};
    end
  end

  // Only the addressed lane is replaced; the other lanes keep the value just read.
  always_comb begin
    mergedWord = mem_dout_in;
    if (size_q == 2'b00) begin
      mergedWord[{addr_q[1:0], 3'b000} +: 8] = wdataLo_q[7:0];
    end else begin
      mergedWord[{addr_q[1], 4'b0000} +: 16] = wdataLo_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    uns_d     = uns_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdataLo_d = wdataLo_q;
    rdata_d   = rdata_q;
    din_d     = din_q;
    case (state_q)
      S_IDLE: begin
        if (req_in) begin
          size_d    = size_in;
          uns_d     = unsigned_in;
          addr_d    = addr_in;
          wdataLo_d = wdata_in[15:0];
          err_d     = misaligned;
          if (misaligned) begin
            state_d = S_RESP;
          end else if (!we_in) begin
            state_d = S_LOAD;
          end else if (size_in == 2'b10) begin
            din_d   = wdata_in;
            state_d = S_WRITE;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        rdata_d = loadResult;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        din_d   = mergedWord;
        state_d = S_WRITE;
      end
      S_WRITE:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdataLo_q <= '0;
      rdata_q   <= '0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdataLo_q <= wdataLo_d;
      rdata_q   <= rdata_d;
      din_q     <= din_d;
    end
  end

  // Write enable is masked by reset so an aborted store never reaches the SRAM.
  assign mem_we_out    = (state_q == S_WRITE) & ~rst;
  assign ready_out     = (state_q == S_IDLE);
  assign done_out      = (state_q == S_RESP);
  assign err_out       = (state_q == S_RESP) & err_q;
  assign rdata_out     = rdata_q;
  assign mem_raddr_out = addr_q;
  assign mem_waddr_out = addr_q;
  assign mem_din_out   = din_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Scoreboard bench for dmem_lsu_ctrl with a behavioural 4 KB SRAM attached.
module tb_dmem_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_in, we_in, unsigned_in;
  logic [1:0]  size_in;
  logic [11:0] addr_in;
  logic [31:0] wdata_in;
  logic        ready_out, done_out, err_out, mem_we_out;
  logic [31:0] rdata_out, mem_dout_in, mem_din_out;
  logic [11:0] mem_raddr_out, mem_waddr_out;

  logic [31:0] mem [0:1023];

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          weCnt;
    int          weCycle;
    logic [31:0] din;
    logic        readyAfter;
  } resp_t;

  resp_t sbq[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_lsu_ctrl #(.DATA_W(32), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .we_in(we_in), .size_in(size_in),
    .unsigned_in(unsigned_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .ready_out(ready_out), .done_out(done_out), .err_out(err_out), .rdata_out(rdata_out),
    .mem_raddr_out(mem_raddr_out), .mem_dout_in(mem_dout_in), .mem_waddr_out(mem_waddr_out),
    .mem_din_out(mem_din_out), .mem_we_out(mem_we_out)
  );

  assign mem_dout_in = mem[mem_raddr_out[11:2]];

  always @(posedge clk) begin
    if (mem_we_out) mem[mem_waddr_out[11:2]] <= mem_din_out;
  end

  // Issues one request accepted at edge 0; cycle k is sampled at the negedge after edge k-1.
  task automatic runReq(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata, output resp_t o);
    o.lat = 0; o.err = 1'b0; o.rdata = '0; o.weCnt = 0; o.weCycle = 0; o.din = '0; o.readyAfter = 1'b0;
    @(negedge clk);
    req_in = 1'b1; we_in = we; size_in = size; unsigned_in = uns; addr_in = addr; wdata_in = wdata;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_in = 1'b0;
      if (mem_we_out === 1'b1) begin o.weCnt++; o.weCycle = k; o.din = mem_din_out; end
      if (done_out === 1'b1) begin o.lat = k; o.err = err_out; o.rdata = rdata_out; break; end
    end
    if (o.lat != 0) begin
      @(negedge clk);
      o.readyAfter = ready_out;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_in = 1'b0; we_in = 1'b0; size_in = 2'b00; unsigned_in = 1'b0;
    addr_in = '0; wdata_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ready_out !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready got=%b exp=1", ready_out); end
    checks++; if (done_out !== 1'b0) begin failures++; $display("[TB] FAIL rst_done got=%b exp=0", done_out); end
    checks++; if (err_out !== 1'b0) begin failures++; $display("[TB] FAIL rst_err got=%b exp=0", err_out); end
    checks++; if (rdata_out !== 32'h0) begin failures++; $display("[TB] FAIL rst_rdata got=%h exp=0", rdata_out); end
    checks++; if (mem_we_out !== 1'b0) begin failures++; $display("[TB] FAIL rst_we got=%b exp=0", mem_we_out); end
    checks++; if (mem_raddr_out !== 12'h0) begin failures++; $display("[TB] FAIL rst_raddr got=%h exp=0", mem_raddr_out); end
    checks++; if (mem_waddr_out !== 12'h0) begin failures++; $display("[TB] FAIL rst_waddr got=%h exp=0", mem_waddr_out); end
    checks++; if (mem_din_out !== 32'h0) begin failures++; $display("[TB] FAIL rst_din got=%h exp=0", mem_din_out); end
  endtask

  task automatic test_loads();
    logic [1:0]  sz [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    logic        un [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [11:0] ad [5] = '{12'h013, 12'h013, 12'h012, 12'h010, 12'h010};
    logic [31:0] ex [5] = '{32'hFFFFFF88, 32'h00000088, 32'h00008899, 32'hFFFFAABB, 32'h8899AABB};
    resp_t e, o;
    for (int i = 0; i < 5; i++) begin
      e.lat = 2; e.err = 1'b0; e.rdata = ex[i]; e.weCnt = 0; e.weCycle = 0; e.din = '0; e.readyAfter = 1'b1;
      sbq.push_back(e);
      runReq(1'b0, sz[i], un[i], ad[i], 32'h0, o);
      e = sbq.pop_front();
      checks++; if (o.lat !== e.lat) begin failures++; $display("[TB] FAIL load%0d_lat got=%0d exp=%0d", i, o.lat, e.lat); end
      checks++; if (o.err !== e.err) begin failures++; $display("[TB] FAIL load%0d_err got=%b exp=%b", i, o.err, e.err); end
      checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL load%0d_rdata got=%h exp=%h", i, o.rdata, e.rdata); end
      checks++; if (o.weCnt !== e.weCnt) begin failures++; $display("[TB] FAIL load%0d_we got=%0d exp=%0d", i, o.weCnt, e.weCnt); end
    end
  endtask

  task automatic test_sub_word_store();
    logic        isHalf [2] = '{1'b0, 1'b1};
    logic [11:0] ad [2] = '{12'h011, 12'h012};
    logic [31:0] wd [2] = '{32'h123456CC, 32'h00001122};
    logic [31:0] ex [2] = '{32'h8899CCBB, 32'h1122AABB};
    resp_t e, o;
    for (int i = 0; i < 2; i++) begin
      mem[4] = 32'h8899AABB;
      e.lat = 3; e.err = 1'b0; e.rdata = 32'h8899AABB; e.weCnt = 1; e.weCycle = 2; e.din = ex[i]; e.readyAfter = 1'b1;
      sbq.push_back(e);
      runReq(1'b1, {1'b0, isHalf[i]}, 1'b0, ad[i], wd[i], o);
      e = sbq.pop_front();
      checks++; if (o.lat !== e.lat) begin failures++; $display("[TB] FAIL rmw%0d_lat got=%0d exp=%0d", i, o.lat, e.lat); end
      checks++; if (o.err !== e.err) begin failures++; $display("[TB] FAIL rmw%0d_err got=%b exp=%b", i, o.err, e.err); end
      checks++; if (o.weCnt !== e.weCnt) begin failures++; $display("[TB] FAIL rmw%0d_wecnt got=%0d exp=%0d", i, o.weCnt, e.weCnt); end
      checks++; if (o.weCycle !== e.weCycle) begin failures++; $display("[TB] FAIL rmw%0d_wecyc got=%0d exp=%0d", i, o.weCycle, e.weCycle); end
      checks++; if (o.din !== e.din) begin failures++; $display("[TB] FAIL rmw%0d_din got=%h exp=%h", i, o.din, e.din); end
      checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL rmw%0d_rdata got=%h exp=%h", i, o.rdata, e.rdata); end
      checks++; if (mem[4] !== ex[i]) begin failures++; $display("[TB] FAIL rmw%0d_mem got=%h exp=%h", i, mem[4], ex[i]); end
    end
    e.lat = 2; e.rdata = 32'h1122AABB;
    sbq.push_back(e);
    runReq(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, o);
    e = sbq.pop_front();
    checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL rmw_readback got=%h exp=%h", o.rdata, e.rdata); end
  endtask

  task automatic test_word_store();
    resp_t e, o;
    e.lat = 2; e.err = 1'b0; e.rdata = 32'h1122AABB; e.weCnt = 1; e.weCycle = 1; e.din = 32'hDEADBEEF; e.readyAfter = 1'b1;
    sbq.push_back(e);
    runReq(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, o);
    e = sbq.pop_front();
    checks++; if (o.lat !== e.lat) begin failures++; $display("[TB] FAIL sw_lat got=%0d exp=%0d", o.lat, e.lat); end
    checks++; if (o.weCnt !== e.weCnt) begin failures++; $display("[TB] FAIL sw_wecnt got=%0d exp=%0d", o.weCnt, e.weCnt); end
    checks++; if (o.weCycle !== e.weCycle) begin failures++; $display("[TB] FAIL sw_wecyc got=%0d exp=%0d", o.weCycle, e.weCycle); end
    checks++; if (o.din !== e.din) begin failures++; $display("[TB] FAIL sw_din got=%h exp=%h", o.din, e.din); end
    checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL sw_rdata got=%h exp=%h", o.rdata, e.rdata); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL sw_mem got=%h exp=deadbeef", mem[4]); end
  endtask

  task automatic test_errors();
    logic        we [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
    logic [11:0] ad [3] = '{12'h012, 12'h011, 12'h010};
    resp_t e, o;
    for (int i = 0; i < 3; i++) begin
      e.lat = 1; e.err = 1'b1; e.rdata = 32'h1122AABB; e.weCnt = 0; e.weCycle = 0; e.din = '0; e.readyAfter = 1'b1;
      sbq.push_back(e);
      runReq(we[i], sz[i], 1'b0, ad[i], 32'h0BADF00D, o);
      e = sbq.pop_front();
      checks++; if (o.lat !== e.lat) begin failures++; $display("[TB] FAIL err%0d_lat got=%0d exp=%0d", i, o.lat, e.lat); end
      checks++; if (o.err !== e.err) begin failures++; $display("[TB] FAIL err%0d_err got=%b exp=%b", i, o.err, e.err); end
      checks++; if (o.weCnt !== e.weCnt) begin failures++; $display("[TB] FAIL err%0d_we got=%0d exp=%0d", i, o.weCnt, e.weCnt); end
      checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL err%0d_rdata got=%h exp=%h", i, o.rdata, e.rdata); end
      checks++; if (mem[4] !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL err%0d_mem got=%h exp=deadbeef", i, mem[4]); end
    end
  endtask

  task automatic test_reset_midop();
    int weSeen = 0;
    int doneSeen = 0;
    @(negedge clk);
    req_in = 1'b1; we_in = 1'b1; size_in = 2'b00; unsigned_in = 1'b0; addr_in = 12'h010; wdata_in = 32'h00000077;
    @(posedge clk);
    @(negedge clk);
    req_in = 1'b0;
    checks++; if (ready_out !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b exp=0", ready_out); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ready_out !== 1'b1) begin failures++; $display("[TB] FAIL midrst_ready got=%b exp=1", ready_out); end
    for (int k = 0; k < 4; k++) begin
      if (mem_we_out === 1'b1) weSeen++;
      if (done_out === 1'b1) doneSeen++;
      @(negedge clk);
    end
    checks++; if (weSeen !== 0) begin failures++; $display("[TB] FAIL midrst_we got=%0d exp=0", weSeen); end
    checks++; if (doneSeen !== 0) begin failures++; $display("[TB] FAIL midrst_done got=%0d exp=0", doneSeen); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL midrst_mem got=%h exp=deadbeef", mem[4]); end
  endtask

  task automatic test_busy_ignored();
    int weSeen = 0;
    int doneSeen = 0;
    int doneCycle = 0;
    logic [31:0] rd = '0;
    @(negedge clk);
    req_in = 1'b1; we_in = 1'b0; size_in = 2'b10; unsigned_in = 1'b0; addr_in = 12'h010; wdata_in = 32'h0;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_in = 1'b1; we_in = 1'b1; size_in = 2'b10; addr_in = 12'h020; wdata_in = 32'h55555555;
      end else begin
        req_in = 1'b0;
      end
      if (mem_we_out === 1'b1) weSeen++;
      if (done_out === 1'b1) begin doneSeen++; doneCycle = k; rd = rdata_out; end
    end
    checks++; if (doneSeen !== 1) begin failures++; $display("[TB] FAIL busy_donecnt got=%0d exp=1", doneSeen); end
    checks++; if (doneCycle !== 2) begin failures++; $display("[TB] FAIL busy_lat got=%0d exp=2", doneCycle); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL busy_rdata got=%h exp=deadbeef", rd); end
    checks++; if (weSeen !== 0) begin failures++; $display("[TB] FAIL busy_we got=%0d exp=0", weSeen); end
    checks++; if (mem[8] !== 32'h0) begin failures++; $display("[TB] FAIL busy_mem got=%h exp=0", mem[8]); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] ad [2] = '{12'h010, 12'h012};
    logic [1:0]  sz [2] = '{2'b00, 2'b01};
    logic [31:0] ex [2] = '{32'h000000EF, 32'h0000DEAD};
    resp_t e, o;
    for (int i = 0; i < 2; i++) begin
      e.lat = 2; e.err = 1'b0; e.rdata = ex[i]; e.weCnt = 0; e.weCycle = 0; e.din = '0; e.readyAfter = 1'b1;
      sbq.push_back(e);
    end
    for (int i = 0; i < 2; i++) begin
      runReq(1'b0, sz[i], 1'b1, ad[i], 32'h0, o);
      e = sbq.pop_front();
      checks++; if (o.lat !== e.lat) begin failures++; $display("[TB] FAIL b2b%0d_lat got=%0d exp=%0d", i, o.lat, e.lat); end
      checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL b2b%0d_rdata got=%h exp=%h", i, o.rdata, e.rdata); end
      checks++; if (o.readyAfter !== e.readyAfter) begin failures++; $display("[TB] FAIL b2b%0d_ready got=%b exp=%b", i, o.readyAfter, e.readyAfter); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;
    test_reset();
    test_loads();
    test_sub_word_store();
    test_word_store();
    test_errors();
    test_reset_midop();
    test_busy_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
